led_breathe_pwm: RTL and testbench

//   Downstream consumer of the on-chip HF oscillator clock; replaces the fixed LED toggle.

---
 rtl/led_breathe_pwm_pkg.sv | 20 ++
 rtl/led_breathe_pwm_pwm_core.sv | 65 ++++++
 rtl/led_breathe_pwm.sv | 130 +++++++++++++
 tb/tb_led_breathe_pwm.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/led_breathe_pwm_pkg.sv
// Shared types and width helpers for the LED breathing PWM block.
package led_pkg;

  typedef enum logic [1:0] {
    RAMP_UP = 2'd0,
    HOLD_HI = 2'd1,
    RAMP_DN = 2'd2,
    HOLD_LO = 2'd3
  } state_e;

  function automatic int unsigned dmax(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_breathe_pwm_pwm_core.sv
// PWM counter, period-synchronised duty latch and LED compare register.
// LED_BREATHE_GAMMA_EN selects a squared (perceptual) duty curve.
module pwm_core
  import led_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [PWM_W-1:0] i_duty,
  output logic             o_led
);

  localparam logic [PWM_W-1:0] DMAX = PWM_W'(dmax(PWM_W));

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_eff_q, duty_eff_d;
  logic             led_q, led_d;
  logic [PWM_W-1:0] eff_load_s;

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_W-1:0] sq_s;

  // Gamma curve: upper half of the squared duty.
  always_comb begin
    sq_s       = {{PWM_W{1'b0}}, i_duty} * {{PWM_W{1'b0}}, i_duty};
    eff_load_s = sq_s[2*PWM_W-1:PWM_W];
  end
`else
  // Linear curve: raw duty is used directly.
  always_comb begin
    eff_load_s = i_duty;
  end
`endif

  // Next-state for counter, latched duty and LED compare.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + PWM_W'(1);
    duty_eff_d = duty_eff_q;
    led_d      = i_en & (pwm_cnt_q < duty_eff_q);
    // Only reload at the wrap so a period's high-time is never cut short.
    if (pwm_cnt_q == DMAX) begin
      duty_eff_d = eff_load_s;
    end else begin
      duty_eff_d = duty_eff_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pwm_cnt_q  <= '0;
      duty_eff_q <= '0;
      led_q      <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      duty_eff_q <= duty_eff_d;
      led_q      <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/led_breathe_pwm.sv
// LED breathing pattern: prescaled triangle duty ramp driving pwm_core.
// Optional macro LED_BREATHE_GAMMA_EN enables the gamma curve in pwm_core.
module led_breathe_pwm
  import led_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned STEP_DIV   = 4096,
  parameter int unsigned HOLD_STEPS = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_led,
  output logic [1:0]       o_phase,
  output logic [PWM_W-1:0] o_duty,
  output logic             o_cycle_done
);

  localparam int unsigned      PRESC_W = cnt_w(STEP_DIV);
  localparam int unsigned      HOLD_W  = cnt_w(HOLD_STEPS);
  localparam logic [PWM_W-1:0] DMAX    = PWM_W'(dmax(PWM_W));
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 32'd1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_STEPS - 32'd1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic               done_q, done_d;
  logic               tick_s;

  // Step-tick prescaler; frozen while disabled.
  always_comb begin
    tick_s  = i_en & (presc_q == PRESC_LAST);
    presc_d = presc_q;
    if (tick_s) begin
      presc_d = '0;
    end else if (i_en) begin
      presc_d = presc_q + PRESC_W'(1);
    end else begin
      presc_d = presc_q;
    end
  end

  // Triangle FSM; advances only on step ticks.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (tick_s) begin
      case (state_q)
        RAMP_UP: begin
          if (duty_q == DMAX) begin
            state_d = HOLD_HI;
            hold_d  = '0;
          end else begin
            duty_d = duty_q + PWM_W'(1);
          end
        end
        HOLD_HI: begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP_DN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        RAMP_DN: begin
          if (duty_q == '0) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end else begin
            duty_d = duty_q - PWM_W'(1);
          end
        end
        HOLD_LO: begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP_UP;
            hold_d  = '0;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = RAMP_UP;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RAMP_UP;
      presc_q <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  pwm_core #(
    .PWM_W (PWM_W)
  ) u_pwm_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_duty (duty_q),
    .o_led  (o_led)
  );

  assign o_phase      = state_q;
  assign o_duty       = duty_q;
  assign o_cycle_done = done_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Self-checking bench for led_breathe_pwm (PWM_W=4, STEP_DIV=4, HOLD_STEPS=2).
module tb_led_breathe_pwm;

  localparam int W   = 4;
  localparam int SD  = 4;
  localparam int H   = 2;
  localparam int D   = (1 << W) - 1;
  localparam int PER = 2 * (D + 1) + 2 * H;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         led;
  logic [1:0]   phase;
  logic [W-1:0] duty;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: counts of clocks/ticks since reset.
  int m_pcnt, m_eff, m_enclk, m_ticks;
  bit m_led, m_done;

  always #5 clk = ~clk;

  led_breathe_pwm #(.PWM_W(W), .STEP_DIV(SD), .HOLD_STEPS(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_led(led),
    .o_phase(phase), .o_duty(duty), .o_cycle_done(done)
  );

  function automatic int g(input int d);
`ifdef LED_BREATHE_GAMMA_EN
    return (d * d) / (1 << W);
`else
    return d;
`endif
  endfunction

  // Position inside one breath, measured in step ticks.
  function automatic int duty_of(input int t);
    int p = t % PER;
    if (p <= D) return p;
    if (p <= D + H) return D;
    if (p <= 2 * D + 1 + H) return D - (p - (D + 1 + H));
    return 0;
  endfunction

  function automatic int phase_of(input int t);
    int p = t % PER;
    if (p <= D) return 0;
    if (p <= D + H) return 1;
    if (p <= 2 * D + 1 + H) return 2;
    return 3;
  endfunction

  task automatic model_step(input bit r, input bit e);
    if (r) begin
      m_pcnt = 0; m_eff = 0; m_enclk = 0; m_ticks = 0; m_led = 0; m_done = 0;
    end else begin
      m_led = e && (m_pcnt < m_eff);
      if (m_pcnt == D) m_eff = g(duty_of(m_ticks));
      m_pcnt = (m_pcnt + 1) % (D + 1);
      m_done = 0;
      if (e) begin
        m_enclk++;
        if (m_enclk % SD == 0) begin
          m_ticks++;
          if (m_ticks % PER == 0) m_done = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    n_tests++;
    if (led !== m_led || int'(phase) != phase_of(m_ticks) ||
        int'(duty) != duty_of(m_ticks) || done !== m_done) begin
      n_fail++;
      $display("FAIL model t=%0t: led=%b phase=%0d duty=%0d done=%b, want led=%b phase=%0d duty=%0d done=%b",
               $time, led, phase, duty, done, m_led, phase_of(m_ticks), duty_of(m_ticks), m_done);
    end
  endtask

  typedef struct {
    bit rst;
    bit en;
    int n;
    int exp_phase;
    int exp_duty;
    int exp_led;   // LED-high clocks over the record; -1 = not checked
    int exp_done;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[16];
    int   nv = 0;
    int   ledc, donec;

    vecs[nv++] = '{1'b1, 1'b0, 1,  0, 0,  0, 0};       // reset state
    vecs[nv++] = '{1'b0, 1'b1, 16, 0, 4,  0, 0};       // duty_eff=0 period: dark
    vecs[nv++] = '{1'b0, 1'b1, 14, 0, 7,  g(3), 0};
    vecs[nv++] = '{1'b0, 1'b0, 50, 0, 7,  0, 0};       // disabled: frozen, dark
    vecs[nv++] = '{1'b0, 1'b1, 1,  0, 7,  -1, 0};      // presc resumes at 2
    vecs[nv++] = '{1'b0, 1'b1, 1,  0, 8,  -1, 0};
    vecs[nv++] = '{1'b1, 1'b0, 1,  0, 0,  0, 0};
    vecs[nv++] = '{1'b0, 1'b1, 63, 0, 15, -1, 0};      // phase 0 dwell 64
    vecs[nv++] = '{1'b0, 1'b1, 1,  1, 15, -1, 0};
    vecs[nv++] = '{1'b0, 1'b1, 16, 2, 13, g(15), 0};   // full-duty period
    vecs[nv++] = '{1'b0, 1'b1, 56, 3, 0,  -1, 0};
    vecs[nv++] = '{1'b0, 1'b1, 7,  3, 0,  -1, 0};
    vecs[nv++] = '{1'b0, 1'b1, 1,  0, 0,  -1, 1};      // breath done at clock 144
    vecs[nv++] = '{1'b0, 1'b1, 66, 1, 15, -1, 0};      // into HOLD_HI
    vecs[nv++] = '{1'b1, 1'b1, 1,  0, 0,  0, 0};       // mid-hold reset
    vecs[nv++] = '{1'b0, 1'b1, 3,  0, 0,  -1, 0};

    for (int i = 0; i < nv; i++) begin
      ledc  = 0;
      donec = 0;
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc(vecs[i].rst, vecs[i].en);
        ledc  += int'(led);
        donec += int'(done);
      end
      check($sformatf("vec%0d_phase", i), int'(phase), vecs[i].exp_phase);
      check($sformatf("vec%0d_duty", i), int'(duty), vecs[i].exp_duty);
      check($sformatf("vec%0d_done", i), donec, vecs[i].exp_done);
      if (vecs[i].exp_led >= 0) check($sformatf("vec%0d_led", i), ledc, vecs[i].exp_led);
    end

    // First tick four clocks after reset release.
    cyc(1'b0, 1'b1);
    check("first_tick_duty", int'(duty), 1);

    // Randomised enable and occasional reset against the model.
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
